gcd_engine: RTL and testbench

Parametrised, self-contained GCD unit: controller FSM plus WIDTH-bit datapath. Operands are accepted on a valid/ready input handshake and the result is returned on a valid/ready output handshake. Zero operands are handled explicitly and an iteration count is reported. It is the next-generation drop-in for the fixed-width start/done GCD pair, for use wherever a streaming producer or consumer needs GCD results.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_datapath.sv | 140 ++++++++++++++
 rtl/gcd_engine.sv | 133 +++++++++++++
 tb/tb_gcd_engine.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and counter helper for the GCD engine.
// Optional feature macro: GCD_BINARY_EN (selects Stein's binary algorithm).
package gcd_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    REDUCE   = 3'd2,
    DONE     = 3'd3,
    PRESHIFT = 3'd4
  } state_t;

  // Saturating increment: holds at max_v instead of wrapping to zero.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand, shift-count, result and iteration registers of the GCD engine.
// Optional feature macro: GCD_BINARY_EN (adds the common-factor-of-two register k and shifters).
module gcd_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_fsm_n,
  input  logic             load,
  input  logic             shift_both,
  input  logic             reduce,
  input  logic             capture,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             eq,
  output logic             a_gt_b,
  output logic             a_zero,
  output logic             b_zero,
  output logic             a_even,
  output logic             b_even
);
  import gcd_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;

  assign eq       = (a_q == b_q);
  assign a_gt_b   = (a_q > b_q);
  assign a_zero   = (a_q == '0);
  assign b_zero   = (b_q == '0);
  assign a_even   = ~a_q[0];
  assign b_even   = ~b_q[0];
  assign result   = res_q;
  assign iter_cnt = cnt_q;

`ifdef GCD_BINARY_EN
  localparam int KW = $clog2(WIDTH) + 1;

  logic [KW-1:0] k_q;

  // Common power of two stripped during PRESHIFT, restored when the result is captured.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      k_q <= '0;
    end else if (load) begin
      k_q <= '0;
    end else if (shift_both) begin
      k_q <= k_q + KW'(1);
    end
  end

  // Operand registers: load, strip shared twos, then Stein reduction steps.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (shift_both) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
    end else if (reduce) begin
      if (a_even) begin
        a_q <= a_q >> 1;
      end else if (b_even) begin
        b_q <= b_q >> 1;
      end else if (a_gt_b) begin
        a_q <= a_q - b_q;
      end else begin
        b_q <= b_q - a_q;
      end
    end
  end

  // Result capture; a zero operand short-circuits before any shift so k is irrelevant there.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      res_q <= '0;
    end else if (capture) begin
      if (a_zero || b_zero) begin
        res_q <= a_q | b_q;
      end else begin
        res_q <= a_q << k_q;
      end
    end
  end
`else
  logic unused_shift;
  assign unused_shift = shift_both;

  // Operand registers: load, then subtract the smaller from the larger each REDUCE.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (reduce) begin
      if (a_gt_b) begin
        a_q <= a_q - b_q;
      end else begin
        b_q <= b_q - a_q;
      end
    end
  end

  // Result capture; OR of the operands yields the non-zero one, or 0 for gcd(0,0).
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      res_q <= '0;
    end else if (capture) begin
      if (a_zero || b_zero) begin
        res_q <= a_q | b_q;
      end else begin
        res_q <= a_q;
      end
    end
  end
`endif

  // Iteration counter: cleared on accept, saturating increment per REDUCE cycle.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (reduce) begin
      cnt_q <= CNT_W'(sat_inc(64'(cnt_q), 64'(CNT_MAX)));
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: valid/ready GCD unit, controller FSM around gcd_datapath.
// Optional feature macro: GCD_BINARY_EN (Stein's binary algorithm with a PRESHIFT state).
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_fsm_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             busy
);
  import gcd_pkg::*;

  state_t state_q;
  state_t state_d;

  logic load;
  logic shift_both;
  logic reduce;
  logic capture;
  logic eq;
  logic a_gt_b;
  logic a_zero;
  logic b_zero;
  logic a_even;
  logic b_even;

  gcd_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk        (clk),
    .rst_fsm_n  (rst_fsm_n),
    .load       (load),
    .shift_both (shift_both),
    .reduce     (reduce),
    .capture    (capture),
    .a_in       (a_in),
    .b_in       (b_in),
    .result     (gcd_out),
    .iter_cnt   (iter_cnt),
    .eq         (eq),
    .a_gt_b     (a_gt_b),
    .a_zero     (a_zero),
    .b_zero     (b_zero),
    .a_even     (a_even),
    .b_even     (b_even)
  );

  // The datapath chooses the subtraction direction itself; the FSM only needs the other flags.
`ifdef GCD_BINARY_EN
  logic unused_status;
  assign unused_status = a_gt_b;
`else
  logic unused_status;
  assign unused_status = ^{a_gt_b, a_even, b_even};
`endif

  assign busy = (state_q != IDLE);

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_fsm_n) begin
    if (!rst_fsm_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    shift_both = 1'b0;
    reduce     = 1'b0;
    capture    = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
`ifdef GCD_BINARY_EN
          state_d = PRESHIFT;
`else
          state_d = CHECK;
`endif
        end
      end
`ifdef GCD_BINARY_EN
      PRESHIFT: begin
        if (a_zero || b_zero) begin
          state_d = CHECK;
        end else if (a_even && b_even) begin
          shift_both = 1'b1;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      CHECK: begin
        if (a_zero || b_zero || eq) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        reduce  = 1'b1;
        state_d = CHECK;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized self-checking bench for gcd_engine against a division-based GCD model.
// Optional feature macro: GCD_BINARY_EN (cycle-exact checks apply to the subtraction build only).
module tb_gcd_engine;

  logic       clk = 1'b0;
  logic       rst_fsm_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] gcd_out;
  logic [8:0] iter_cnt;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  gcd_engine #(
    .WIDTH (8),
    .CNT_W (9)
  ) dut (
    .clk       (clk),
    .rst_fsm_n (rst_fsm_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gcd_out   (gcd_out),
    .iter_cnt  (iter_cnt),
    .busy      (busy)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Euclid by remainder: gcd(0,b)=b, gcd(0,0)=0.
  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  // Subtraction count = sum of Euclid quotients minus the final equal-operand step.
  function automatic int ref_steps(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    int t;
    int s = 0;
    if (a == 0 || b == 0) return 0;
    x = (a > b) ? a : b;
    y = (a > b) ? b : a;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    s = s - 1;
    return (s > 511) ? 511 : s;
  endfunction

  // Present a pair, wait for acceptance, then scramble the inputs to prove only the accept edge samples them.
  task automatic do_accept(input logic [7:0] a, input logic [7:0] b);
    int guard = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
  endtask

  // Count cycles from the accept cycle (cycle 0) until out_valid, tracking busy on the way.
  task automatic wait_result(output int lat, output bit ok, output bit busy_ok);
    lat     = 1;
    ok      = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Complete the output handshake after an optional stall.
  task automatic consume(input int stall);
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_fsm_n = 1'b0;
    #3;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
    n_cmp++;
    if (gcd_out !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_gcd_out actual=%0d required=0", gcd_out); end
    n_cmp++;
    if (iter_cnt !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_iter_cnt actual=%0d required=0", iter_cnt); end
    @(posedge clk);
    #2;
    rst_fsm_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int lat;
    bit ok;
    bit bok;
    do_accept(8'd48, 8'd18);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("[TB] FAIL basic_timeout actual=no_valid required=valid"); end
    n_cmp++;
    if (gcd_out !== 8'd6) begin n_fail++; $display("[TB] FAIL basic_gcd actual=%0d required=6", gcd_out); end
`ifdef GCD_BINARY_EN
    n_cmp++;
    if (dut.u_dp.k_q !== 4'd1) begin n_fail++; $display("[TB] FAIL basic_k actual=%0d required=1", dut.u_dp.k_q); end
`else
    n_cmp++;
    if (iter_cnt !== 9'd4) begin n_fail++; $display("[TB] FAIL basic_iter actual=%0d required=4", iter_cnt); end
    n_cmp++;
    if (lat != 10) begin n_fail++; $display("[TB] FAIL basic_latency actual=%0d required=10", lat); end
`endif
    consume(0);
  endtask

  task automatic test_zero;
    int lat;
    bit ok;
    bit bok;
    do_accept(8'd0, 8'd35);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd35) begin n_fail++; $display("[TB] FAIL zero_gcd actual=%0d required=35", gcd_out); end
    n_cmp++;
    if (iter_cnt !== 9'd0) begin n_fail++; $display("[TB] FAIL zero_iter actual=%0d required=0", iter_cnt); end
`ifndef GCD_BINARY_EN
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("[TB] FAIL zero_latency actual=%0d required=2", lat); end
`endif
    consume(1);
    do_accept(8'd0, 8'd0);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd0) begin n_fail++; $display("[TB] FAIL zero_zero_gcd actual=%0d required=0", gcd_out); end
    consume(0);
  endtask

  task automatic test_worst;
    int lat;
    bit ok;
    bit bok;
    do_accept(8'd255, 8'd1);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd1) begin n_fail++; $display("[TB] FAIL worst_gcd actual=%0d required=1", gcd_out); end
    n_cmp++;
    if (!bok || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL worst_busy actual=dropped required=held"); end
`ifndef GCD_BINARY_EN
    n_cmp++;
    if (iter_cnt !== 9'd254) begin n_fail++; $display("[TB] FAIL worst_iter actual=%0d required=254", iter_cnt); end
    n_cmp++;
    if (lat != 510) begin n_fail++; $display("[TB] FAIL worst_latency actual=%0d required=510", lat); end
`endif
    consume(0);
  endtask

  task automatic test_backpressure;
    int lat;
    bit ok;
    bit bok;
    do_accept(8'd12, 8'd8);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd4) begin n_fail++; $display("[TB] FAIL bp_gcd actual=%0d required=4", gcd_out); end
    in_valid = 1'b1;
    a_in     = 8'd5;
    b_in     = 8'd15;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || gcd_out !== 8'd4) begin
        n_fail++;
        $display("[TB] FAIL bp_hold cycle=%0d actual=%b/%0d required=1/4", i, out_valid, gcd_out);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready cycle=%0d actual=%b required=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_next_ready actual=%b/%b required=1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_next_accept actual=%b required=1", busy); end
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd5) begin n_fail++; $display("[TB] FAIL bp_next_gcd actual=%0d required=5", gcd_out); end
    consume(0);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    bit bok;
    do_accept(8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_fsm_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_flags actual=%b/%b required=0/1", out_valid, in_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy actual=%b required=0", busy); end
    @(posedge clk);
    #2;
    rst_fsm_n = 1'b1;
    #1;
    do_accept(8'd9, 8'd6);
    wait_result(lat, ok, bok);
    n_cmp++;
    if (!ok || gcd_out !== 8'd3) begin n_fail++; $display("[TB] FAIL midreset_next_gcd actual=%0d required=3", gcd_out); end
    consume(0);
  endtask

  task automatic test_random;
    int lat;
    bit ok;
    bit bok;
    logic [7:0] a;
    logic [7:0] b;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_accept(a, b);
      wait_result(lat, ok, bok);
      n_cmp++;
      if (!ok || gcd_out !== ref_gcd(a, b)) begin
        n_fail++;
        $display("[TB] FAIL rand_gcd a=%0d b=%0d actual=%0d required=%0d", a, b, gcd_out, ref_gcd(a, b));
      end
`ifndef GCD_BINARY_EN
      n_cmp++;
      if (iter_cnt !== 9'(ref_steps(a, b))) begin
        n_fail++;
        $display("[TB] FAIL rand_iter a=%0d b=%0d actual=%0d required=%0d", a, b, iter_cnt, ref_steps(a, b));
      end
      n_cmp++;
      if (lat != 2 + 2 * ref_steps(a, b)) begin
        n_fail++;
        $display("[TB] FAIL rand_latency a=%0d b=%0d actual=%0d required=%0d", a, b, lat, 2 + 2 * ref_steps(a, b));
      end
`endif
      consume(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    out_ready = 1'b1;
    do_accept(8'd12, 8'd18);
    in_valid = 1'b1;
    a_in     = 8'd21;
    b_in     = 8'd14;
    gap      = 1;
    while (!in_ready && gap < 2000) begin
      @(posedge clk);
      #1;
      gap++;
    end
`ifndef GCD_BINARY_EN
    n_cmp++;
    if (gap != 7) begin n_fail++; $display("[TB] FAIL b2b_spacing actual=%0d required=7", gap); end
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    gap      = 0;
    while (!out_valid && gap < 2000) begin
      @(posedge clk);
      #1;
      gap++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || gcd_out !== 8'd7) begin n_fail++; $display("[TB] FAIL b2b_gcd actual=%0d required=7", gcd_out); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_worst();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
